// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: parametrised convolution sequencer.
// Per output pixel it fills the ifmap window (K columns at the start of each
// row, one column otherwise), then for each filter preloads K weight rows and
// commits them to the MACs. Each new row restarts with a full K-column refill.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   cmd_start/cmd_abort start pulse (taken in IDLE only) / synchronous abort
//   cfg_*               kernel edge K, output map W x H, filter count F
//   ifmap_fifo_empty    ifmap FIFO status
//   weight_valid        BRAM weight row valid
//   load_ifmap          pop/shift one ifmap column
//   weight_preload      capture one weight row (gated by weight_valid)
//   load_weight         commit the preloaded kernel
//   bram_port_sel       weight BRAM port, alternating per row
//   busy, done          not-IDLE flag, one-cycle completion pulse
//   status              {line_cnt, col_cnt, state, err, done_sticky, busy}
module conv_seq_ctrl #(
  parameter int KMAX   = 7,
  parameter int K_W    = 3,
  parameter int DIM_W  = 9,
  parameter int FILT_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [K_W-1:0]    cfg_kernel,
  input  logic [DIM_W-1:0]  cfg_ofmap_w,
  input  logic [DIM_W-1:0]  cfg_ofmap_h,
  input  logic [FILT_W-1:0] cfg_filters,
  input  logic              ifmap_fifo_empty,
  input  logic              weight_valid,
  output logic              load_ifmap,
  output logic              weight_preload,
  output logic              load_weight,
  output logic              bram_port_sel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] status
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, IF_WAIT = 3'd1, IF_LOAD = 3'd2, W_PRE = 3'd3,
    W_LOAD = 3'd4, ADV = 3'd5, DONE = 3'd6
  } state_t;

  typedef struct packed {
    logic [K_W-1:0]    k;
    logic [DIM_W-1:0]  w;
    logic [DIM_W-1:0]  h;
    logic [FILT_W-1:0] f;
  } cfg_t;

  state_t            state_q, state_d;
  cfg_t              cfg_q;
  logic [K_W-1:0]    need_q, if_cnt_q, row_cnt_q;
  logic [FILT_W-1:0] filt_cnt_q;
  logic [DIM_W-1:0]  col_cnt_q, line_cnt_q;
  logic              err_q, done_sticky_q;
  logic              cfg_ok, if_last, row_last, filt_last, col_last, line_last;

  assign cfg_ok = (cfg_kernel != '0) && (cfg_kernel <= K_W'(KMAX)) &&
                  (cfg_ofmap_w != '0) && (cfg_ofmap_h != '0) &&
                  (cfg_filters != '0);

  assign if_last   = (if_cnt_q   == need_q    - 1'b1);
  assign row_last  = (row_cnt_q  == cfg_q.k   - 1'b1);
  assign filt_last = (filt_cnt_q == cfg_q.f   - 1'b1);
  assign col_last  = (col_cnt_q  == cfg_q.w   - 1'b1);
  assign line_last = (line_cnt_q == cfg_q.h   - 1'b1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d        = state_q;
    load_ifmap     = 1'b0;
    weight_preload = 1'b0;
    load_weight    = 1'b0;
    bram_port_sel  = 1'b0;
    done           = 1'b0;
    case (state_q)
      IDLE:    if (cmd_start && cfg_ok) state_d = IF_WAIT;
      IF_WAIT: if (!ifmap_fifo_empty) state_d = IF_LOAD;
      IF_LOAD: begin
        load_ifmap = 1'b1;
        state_d    = if_last ? W_PRE : IF_WAIT;
      end
      W_PRE: begin
        weight_preload = weight_valid;
        bram_port_sel  = row_cnt_q[0];
        if (weight_valid && row_last) state_d = W_LOAD;
      end
      W_LOAD: begin
        load_weight = 1'b1;
        state_d     = filt_last ? ADV : W_PRE;
      end
      ADV:     state_d = (col_last && line_last) ? DONE : IF_WAIT;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a same-cycle start.
    if (cmd_abort) begin
      state_d        = IDLE;
      load_ifmap     = 1'b0;
      weight_preload = 1'b0;
      load_weight    = 1'b0;
      bram_port_sel  = 1'b0;
      done           = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q         <= '0;
      need_q        <= '0;
      if_cnt_q      <= '0;
      row_cnt_q     <= '0;
      filt_cnt_q    <= '0;
      col_cnt_q     <= '0;
      line_cnt_q    <= '0;
      err_q         <= 1'b0;
      done_sticky_q <= 1'b0;
    end else if (cmd_abort) begin
      need_q     <= '0;
      if_cnt_q   <= '0;
      row_cnt_q  <= '0;
      filt_cnt_q <= '0;
      col_cnt_q  <= '0;
      line_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_start) begin
          cfg_q         <= '{k: cfg_kernel, w: cfg_ofmap_w, h: cfg_ofmap_h, f: cfg_filters};
          done_sticky_q <= 1'b0;
          err_q         <= !cfg_ok;
          need_q        <= cfg_kernel;
        end
        IF_LOAD: if_cnt_q <= if_last ? '0 : if_cnt_q + 1'b1;
        W_PRE:   if (weight_valid) row_cnt_q <= row_last ? '0 : row_cnt_q + 1'b1;
        W_LOAD:  filt_cnt_q <= filt_last ? '0 : filt_cnt_q + 1'b1;
        ADV: begin
          if (!col_last) begin
            col_cnt_q <= col_cnt_q + 1'b1;
            need_q    <= K_W'(1);              // slide window by one column
          end else if (!line_last) begin
            col_cnt_q  <= '0;
            line_cnt_q <= line_cnt_q + 1'b1;
            need_q     <= cfg_q.k;             // new row: full refill
          end
        end
        DONE: begin
          done_sticky_q <= 1'b1;
          need_q        <= '0;
          col_cnt_q     <= '0;
          line_cnt_q    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign status = DATA_W'({line_cnt_q, col_cnt_q, state_q, err_q, done_sticky_q, busy});

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: per-cycle expected-state scoreboard for
// the timing scenarios, closed-form strobe totals for full jobs.
module tb_conv_seq_ctrl;
  localparam int KMAX = 7, K_W = 3, DIM_W = 9, FILT_W = 10, DATA_W = 32;
  localparam logic [2:0] S_IDLE = 3'd0, S_IFW = 3'd1, S_IFL = 3'd2, S_WPRE = 3'd3,
                         S_WL = 3'd4, S_ADV = 3'd5, S_DONE = 3'd6;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              cmd_start = 1'b0, cmd_abort = 1'b0;
  logic [K_W-1:0]    cfg_kernel = '0;
  logic [DIM_W-1:0]  cfg_ofmap_w = '0, cfg_ofmap_h = '0;
  logic [FILT_W-1:0] cfg_filters = '0;
  logic              ifmap_fifo_empty = 1'b0, weight_valid = 1'b1;
  logic              load_ifmap, weight_preload, load_weight, bram_port_sel, busy, done;
  logic [DATA_W-1:0] status;

  always #5 clk = ~clk;

  conv_seq_ctrl #(.KMAX(KMAX), .K_W(K_W), .DIM_W(DIM_W), .FILT_W(FILT_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cfg_kernel(cfg_kernel), .cfg_ofmap_w(cfg_ofmap_w), .cfg_ofmap_h(cfg_ofmap_h),
    .cfg_filters(cfg_filters), .ifmap_fifo_empty(ifmap_fifo_empty),
    .weight_valid(weight_valid), .load_ifmap(load_ifmap), .weight_preload(weight_preload),
    .load_weight(load_weight), .bram_port_sel(bram_port_sel), .busy(busy), .done(done),
    .status(status));

  int n_chk = 0, n_err = 0;
  int c_if = 0, c_pre = 0, c_lw = 0, c_done = 0, pre_run = 0;
  int pre_per_lw[$];
  bit seen_wrap = 1'b0;
  logic [2:0] exp_q[$];

  // Strobe counters, sampled mid-cycle after the bench has driven inputs.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (load_ifmap) c_if++;
      if (weight_preload) begin c_pre++; pre_run++; end
      if (load_weight) begin pre_per_lw.push_back(pre_run); pre_run = 0; c_lw++; end
      if (done) c_done++;
      if (busy && status[6+DIM_W +: DIM_W] == 1 && status[6 +: DIM_W] == 0) seen_wrap = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 500000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input int k, input int w, input int h, input int f);
    cfg_kernel  = K_W'(k);
    cfg_ofmap_w = DIM_W'(w);
    cfg_ofmap_h = DIM_W'(h);
    cfg_filters = FILT_W'(f);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic push_st(input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endtask

  task automatic check_cycle(input int cyc);
    logic [2:0] e;
    e = exp_q.pop_front();
    chk($sformatf("state@%0d", cyc), 32'(status[5:3]), 32'(e));
    chk($sformatf("load_ifmap@%0d", cyc), 32'(load_ifmap), 32'(e == S_IFL));
    chk($sformatf("load_weight@%0d", cyc), 32'(load_weight), 32'(e == S_WL));
    chk($sformatf("done@%0d", cyc), 32'(done), 32'(e == S_DONE));
    chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(e != S_IDLE));
  endtask

  task automatic run_idle(input int max, input bit toggle);
    int n;
    n = 0;
    while (busy && n < max) begin
      if (toggle) begin
        weight_valid = ~weight_valid;
        #1;
        if (status[5:3] == S_WPRE) chk("preload_gate", 32'(weight_preload), 32'(weight_valid));
      end
      tick();
      n++;
    end
    chk("run_timeout_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int b_if, b_pre, b_lw, b_done, n;
    int bad_k[5], bad_w[5], bad_h[5], bad_f[5];
    bad_k = '{0, KMAX+1, 3, 3, 3};
    bad_w = '{2, 2, 0, 2, 2};
    bad_h = '{2, 2, 2, 0, 2};
    bad_f = '{2, 2, 2, 2, 0};

    // Reset
    tick(); tick();
    chk("rst_status", status, 32'd0);
    chk("rst_strobes", 32'({load_ifmap, weight_preload, load_weight, bram_port_sel, busy, done}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single pass K=3 W=2 H=1 F=2, timed from the start cycle
    b_if = c_if; b_pre = c_pre; b_lw = c_lw; b_done = c_done;
    push_st(S_IFW, 1); push_st(S_IFL, 1); push_st(S_IFW, 1); push_st(S_IFL, 1);
    push_st(S_IFW, 1); push_st(S_IFL, 1);
    push_st(S_WPRE, 3); push_st(S_WL, 1); push_st(S_WPRE, 3); push_st(S_WL, 1);
    push_st(S_ADV, 1); push_st(S_IFW, 1); push_st(S_IFL, 1);
    push_st(S_WPRE, 3); push_st(S_WL, 1); push_st(S_WPRE, 3); push_st(S_WL, 1);
    push_st(S_ADV, 1); push_st(S_DONE, 1); push_st(S_IDLE, 1);
    start(3, 2, 1, 2);
    for (int c = 1; c <= 28; c++) begin
      check_cycle(c);
      if (c < 28) tick();
    end
    tick();
    chk("t1_ifmap_total", 32'(c_if - b_if), 32'd4);
    chk("t1_preload_total", 32'(c_pre - b_pre), 32'd12);
    chk("t1_lw_total", 32'(c_lw - b_lw), 32'd4);
    chk("t1_done_count", 32'(c_done - b_done), 32'd1);
    chk("t1_done_sticky", 32'(status[1]), 32'd1);
    chk("t1_counters_clear", 32'(status[DATA_W-1:6]), 32'd0);

    // Row wrap K=2 W=2 H=2 F=1
    b_if = c_if; b_pre = c_pre; b_lw = c_lw; b_done = c_done; seen_wrap = 1'b0;
    start(2, 2, 2, 1);
    chk("t2_sticky_cleared", 32'(status[1]), 32'd0);
    run_idle(200, 1'b0);
    tick();
    chk("t2_ifmap_total", 32'(c_if - b_if), 32'd6);
    chk("t2_preload_total", 32'(c_pre - b_pre), 32'd8);
    chk("t2_lw_total", 32'(c_lw - b_lw), 32'd4);
    chk("t2_done_count", 32'(c_done - b_done), 32'd1);
    chk("t2_line_wrap_seen", 32'(seen_wrap), 32'd1);

    // Backpressure: FIFO empty holds IF_WAIT, weight_valid toggling gates preload
    b_if = c_if;
    ifmap_fifo_empty = 1'b1;
    start(2, 1, 1, 2);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_state", 32'(status[5:3]), 32'(S_IFW));
      chk("bp_no_ifmap", 32'(load_ifmap), 32'd0);
      tick();
    end
    chk("bp_ifmap_none", 32'(c_if - b_if), 32'd0);
    ifmap_fifo_empty = 1'b0;
    pre_per_lw.delete();
    pre_run = 0;
    run_idle(300, 1'b1);
    weight_valid = 1'b1;
    tick();
    chk("bp_lw_count", 32'(pre_per_lw.size()), 32'd2);
    while (pre_per_lw.size() > 0) chk("bp_pre_per_lw", 32'(pre_per_lw.pop_front()), 32'd2);

    // Illegal configs, one field at a time
    for (int i = 0; i < 5; i++) begin
      b_if = c_if; b_pre = c_pre; b_lw = c_lw;
      start(bad_k[i], bad_w[i], bad_h[i], bad_f[i]);
      chk($sformatf("ill%0d_err", i), 32'(status[2]), 32'd1);
      chk($sformatf("ill%0d_busy", i), 32'(busy), 32'd0);
      tick(); tick();
      chk($sformatf("ill%0d_state", i), 32'(status[5:3]), 32'(S_IDLE));
      chk($sformatf("ill%0d_strobes", i), 32'((c_if - b_if) + (c_pre - b_pre) + (c_lw - b_lw)), 32'd0);
    end
    start(2, 1, 1, 2);
    chk("legal_clears_err", 32'(status[2]), 32'd0);
    chk("legal_busy", 32'(busy), 32'd1);

    // Abort in W_PRE of the second filter
    b_lw = c_lw; b_done = c_done; n = 0;
    while (!((c_lw - b_lw) >= 1 && status[5:3] == S_WPRE) && n < 50) begin tick(); n++; end
    chk("abort_reach_wpre", 32'(status[5:3]), 32'(S_WPRE));
    cmd_abort = 1'b1;
    #1;
    chk("abort_strobes_forced", 32'({load_ifmap, weight_preload, load_weight, done}), 32'd0);
    tick();
    cmd_abort = 1'b0;
    chk("abort_state", 32'(status[5:3]), 32'(S_IDLE));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_counters", 32'(status[DATA_W-1:6]), 32'd0);
    chk("abort_err_kept", 32'(status[2]), 32'd0);
    tick();
    chk("abort_no_done", 32'(c_done - b_done), 32'd0);

    // Abort together with start in IDLE
    cfg_kernel = 3'd2; cfg_ofmap_w = 9'd1; cfg_ofmap_h = 9'd1; cfg_filters = 10'd1;
    cmd_start = 1'b1; cmd_abort = 1'b1;
    tick();
    cmd_start = 1'b0; cmd_abort = 1'b0;
    chk("abort_start_idle", 32'(status[5:3]), 32'(S_IDLE));
    chk("abort_start_busy", 32'(busy), 32'd0);

    // Boundary K=W=H=F=1
    exp_q.delete();
    push_st(S_IFW, 1); push_st(S_IFL, 1); push_st(S_WPRE, 1); push_st(S_WL, 1);
    push_st(S_ADV, 1); push_st(S_DONE, 1); push_st(S_IDLE, 1);
    start(1, 1, 1, 1);
    for (int c = 1; c <= 7; c++) begin
      check_cycle(c);
      if (c < 7) tick();
    end

    // Reset in the middle of a second job
    start(3, 4, 4, 3);
    for (int c = 0; c < 8; c++) tick();
    chk("midrun_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_rst_status", status, 32'd0);
    chk("midrun_rst_outs", 32'({load_ifmap, weight_preload, load_weight, bram_port_sel, busy, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(status), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
